ins_fetcher: RTL and testbench

- Sequential instruction-fetch front end. Feeds the decoder one 32-bit instruction plus its PC at a time.
- Walks the PC in +4 steps and requests each word from the memory controller over a single-outstanding request/done handshake.
- Obeys the decoder's back-pressure (`IFetcher_stall`) and redirect (`IFetcher_clear` / `IFetcher_new_addr`).
- Sits between the memory controller and the decoder. It is the producer end of the decoder's instruction interface.

---
 rtl/ins_fetcher.sv | 151 +++++++++++++++
 tb/tb_ins_fetcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetcher.sv
// Sequential instruction fetcher: walks the PC in +4 steps, one outstanding memory request at a time.
// Optional direct-mapped word cache enabled by defining IFETCH_ICACHE_EN.
module ins_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] pc,
  input  logic        IFetcher_stall,
  input  logic        IFetcher_clear,
  input  logic [31:0] IFetcher_new_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t      state, state_d;
  logic [31:0] fetch_pc, fetch_pc_d, ins_d, pc_d, mem_addr_d;
  logic        ins_ready_d, mem_req_d;
  logic        consume, hit;
  logic [31:0] hit_data;

  assign consume = ins_ready && !IFetcher_stall;

`ifdef IFETCH_ICACHE_EN
  // ICACHE_LINES must be a power of two, at least 2.
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]             c_data [ICACHE_LINES];
  logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] c_vld;
  logic [IDX_W-1:0]        lk_idx, fl_idx;

  assign lk_idx   = fetch_pc[IDX_W+1:2];
  assign fl_idx   = mem_addr[IDX_W+1:2];
  assign hit      = c_vld[lk_idx] && (c_tag[lk_idx] == fetch_pc[31:IDX_W+2]);
  assign hit_data = c_data[lk_idx];

  // Drained responses are still real memory contents, so they fill too.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      c_vld <= '0;
    end else if (rdy_in && mem_done && state != IDLE) begin
      c_vld[fl_idx]  <= 1'b1;
      c_data[fl_idx] <= mem_data;
      c_tag[fl_idx]  <= mem_addr[31:IDX_W+2];
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d     = state;
    fetch_pc_d  = fetch_pc;
    ins_d       = ins;
    pc_d        = pc;
    ins_ready_d = ins_ready;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    if (consume) ins_ready_d = 1'b0;

    case (state)
      IDLE: begin
        if (!ins_ready || consume) begin
          if (hit) begin
            ins_d       = hit_data;
            pc_d        = fetch_pc;
            ins_ready_d = 1'b1;
            fetch_pc_d  = fetch_pc + 32'd4;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_done) begin
          ins_d       = mem_data;
          pc_d        = fetch_pc;
          ins_ready_d = 1'b1;
          fetch_pc_d  = fetch_pc + 32'd4;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over everything above; an in-flight request must still complete.
    if (IFetcher_clear) begin
      fetch_pc_d  = IFetcher_new_addr;
      ins_ready_d = 1'b0;
      ins_d       = ins;
      pc_d        = pc;
      case (state)
        WAIT: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d   = DRAIN;
          end
        end
        DRAIN: ;
        default: begin
          mem_req_d  = 1'b0;
          mem_addr_d = mem_addr;
          state_d    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      ins       <= '0;
      pc        <= '0;
      ins_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else if (rdy_in) begin
      state     <= state_d;
      fetch_pc  <= fetch_pc_d;
      ins       <= ins_d;
      pc        <= pc_d;
      ins_ready <= ins_ready_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: scoreboarded deliveries, table-driven stream, hand-written redirect/cache/wrap cases.
module tb_ins_fetcher;

  logic        clk = 1'b0;
  logic        rst_n, rdy, stall, clr, mem_done;
  logic [31:0] new_addr, mem_data;
  logic        ins_ready, mem_req;
  logic [31:0] ins, pc, mem_addr;

  logic        w_done, w_ready, w_req;
  logic [31:0] w_data, w_ins, w_pc, w_addr;

  int tests = 0;
  int fails = 0;

  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  exp_t sb[$];

  typedef struct {int lat; int pz; int stl; logic [31:0] data;} vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  ins_fetcher dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .ins_ready(ins_ready), .ins(ins), .pc(pc),
    .IFetcher_stall(stall), .IFetcher_clear(clr), .IFetcher_new_addr(new_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data)
  );

  ins_fetcher #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(1'b1),
    .ins_ready(w_ready), .ins(w_ins), .pc(w_pc),
    .IFetcher_stall(1'b0), .IFetcher_clear(1'b0), .IFetcher_new_addr(32'h0),
    .mem_req(w_req), .mem_addr(w_addr), .mem_done(w_done), .mem_data(w_data)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_1357;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    check("ins_ready", 32'(ins_ready), 32'd1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got output pc %h expected nothing queued", pc);
    end else begin
      e = sb.pop_front();
      check("ins", ins, e.ins);
      check("pc", pc, e.pc);
    end
  endtask

  task automatic deliver(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{a, d});
    mem_data = d;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_out();
  endtask

  task automatic drain_junk(input logic [31:0] a);
    mem_data = memword(a);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    vecs[0] = '{lat: 0, pz: 0, stl: 0, data: 32'h1111_0001};
    vecs[1] = '{lat: 3, pz: 0, stl: 2, data: 32'hDEAD_BEEF};
    vecs[2] = '{lat: 1, pz: 2, stl: 0, data: 32'h0000_0000};
    vecs[3] = '{lat: 5, pz: 0, stl: 4, data: 32'hFFFF_FFFF};
    vecs[4] = '{lat: 0, pz: 3, stl: 1, data: 32'h8000_0013};
    vecs[5] = '{lat: 2, pz: 1, stl: 0, data: 32'h00A0_0513};

    rst_n = 1'b0; rdy = 1'b1; stall = 1'b0; clr = 1'b0; new_addr = '0;
    mem_done = 1'b0; mem_data = '0; w_done = 1'b0; w_data = '0;
    repeat (3) tick();
    check("rst_ins_ready", 32'(ins_ready), 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    // first request appears the cycle after release
    rst_n = 1'b1;
    tick();
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'd0);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

    w_data = 32'h0BAD_F00D; w_done = 1'b1;
    tick();
    w_done = 1'b0;
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_ready", 32'(w_ready), 32'd1);
    tick();
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_addr", w_addr, 32'd0);

    deliver(32'd0, 32'h0050_0093);
    check("first_req_drop", 32'(mem_req), 32'd0);

    // stall holds the buffer and blocks the refill
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ins", ins, 32'h0050_0093);
      check("stall_pc", pc, 32'd0);
      check("stall_req", 32'(mem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    check("unstall_req", 32'(mem_req), 32'd1);
    check("unstall_addr", mem_addr, 32'd4);
    check("unstall_ready", 32'(ins_ready), 32'd0);

    deliver(32'd4, memword(32'd4));
    tick();
    check("wait8_addr", mem_addr, 32'd8);

    // redirect while waiting on addr 8
    clr = 1'b1; new_addr = 32'h100;
    tick();
    clr = 1'b0;
    check("redir_ready", 32'(ins_ready), 32'd0);
    check("redir_drain_req", 32'(mem_req), 32'd1);
    check("redir_drain_addr", mem_addr, 32'd8);
    drain_junk(32'd8);
    check("redir_drop_ready", 32'(ins_ready), 32'd0);
    check("redir_idle_req", 32'(mem_req), 32'd0);
    tick();
    check("redir_req", 32'(mem_req), 32'd1);
    check("redir_addr", mem_addr, 32'h100);
    deliver(32'h100, memword(32'h100));

    // clear on the same edge as mem_done
    tick();
    check("wait104_addr", mem_addr, 32'h104);
    clr = 1'b1; new_addr = 32'h200; mem_data = 32'h5555_5555; mem_done = 1'b1;
    tick();
    clr = 1'b0; mem_done = 1'b0;
    check("coinc_ready", 32'(ins_ready), 32'd0);
    check("coinc_req", 32'(mem_req), 32'd0);
    tick();
    check("coinc_next_req", 32'(mem_req), 32'd1);
    check("coinc_next_addr", mem_addr, 32'h200);
    deliver(32'h200, memword(32'h200));

    // clear from IDLE overrides a simultaneous consume
    clr = 1'b1; new_addr = 32'h300;
    tick();
    clr = 1'b0;
    check("idle_clr_ready", 32'(ins_ready), 32'd0);
    check("idle_clr_req", 32'(mem_req), 32'd0);
    tick();
    check("idle_clr_next_req", 32'(mem_req), 32'd1);
    exp_addr = 32'h300;

    for (int i = 0; i < 6; i++) begin
      check("tbl_req", 32'(mem_req), 32'd1);
      check("tbl_addr", mem_addr, exp_addr);
      rdy = 1'b0;
      repeat (vecs[i].pz) tick();
      rdy = 1'b1;
      check("tbl_pause_req", 32'(mem_req), 32'd1);
      check("tbl_pause_addr", mem_addr, exp_addr);
      repeat (vecs[i].lat) tick();
      deliver(exp_addr, vecs[i].data);
      stall = 1'b1;
      repeat (vecs[i].stl) tick();
      check("tbl_hold_req", 32'(mem_req), 32'd0);
      stall = 1'b0;
      tick();
      exp_addr = exp_addr + 32'd4;
    end

    // cache scenario: fetch 0,4,8 then come back to 0
    clr = 1'b1; new_addr = 32'h0;
    tick();
    clr = 1'b0;
    drain_junk(exp_addr);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("c1_req", 32'(mem_req), 32'd1);
      check("c1_addr", mem_addr, 32'(4 * k));
      deliver(32'(4 * k), memword(32'(4 * k)));
      tick();
    end
    check("c1_end_addr", mem_addr, 32'd12);
    clr = 1'b1; new_addr = 32'h0;
    tick();
    clr = 1'b0;
    drain_junk(32'd12);
`ifdef IFETCH_ICACHE_EN
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{32'(4 * k), memword(32'(4 * k))});
      tick();
      check_out();
      check("c2_hit_noreq", 32'(mem_req), 32'd0);
    end
`else
    for (int k = 0; k < 3; k++) begin
      tick();
      check("c2_req", 32'(mem_req), 32'd1);
      check("c2_addr", mem_addr, 32'(4 * k));
      deliver(32'(4 * k), memword(32'(4 * k)));
    end
`endif

    // reset in the middle of activity, then a clean first request
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_ready", 32'(ins_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("postrst_req", 32'(mem_req), 32'd1);
    check("postrst_addr", mem_addr, 32'd0);
    deliver(32'd0, 32'h0050_0093);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
